// File: rtl/sorted_insert_pkg.sv
// Shared constants and FSM state encoding for the sorted-insert engine.
package sorted_insert_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_PLACE,
        S_DONE
    } state_t;

endpackage

// File: rtl/sorted_insert_ram.sv
// Dual-read, single-write RAM. Both read ports are synchronous (1-cycle latency)
// and return the old word when the same address is written on the same edge.
module ram32x8_dp #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus both registered read ports; no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re_a) begin
            rdata_a <= mem[raddr_a];
        end
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/sorted_insert.sv
// Inserts A into a RAM table kept sorted non-decreasing, shifting larger entries
// up one slot at a time from the top. A separate read port serves the searcher.
module sorted_insert
    import sorted_insert_pkg::*;
#(
    parameter int unsigned DEPTH = sorted_insert_pkg::DEPTH,
    parameter int unsigned WIDTH = sorted_insert_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           A,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       done,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH)-1:0]   ins_addr
);

    localparam int unsigned A_W = $clog2(DEPTH);
    localparam int unsigned C_W = $clog2(DEPTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [A_W-1:0]   i;

    logic             ram_we;
    logic [A_W-1:0]   ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [A_W-1:0]   ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             shift;

    // RAM control: shift mem[i-1] up in S_CMP, drop a_reg into the gap in S_PLACE.
    always_comb begin
        shift     = (state == S_CMP) && (ram_rdata > a_reg);
        ram_re    = (state == S_RD);
        ram_raddr = i - A_W'(1);
        ram_we    = shift || (state == S_PLACE);
        ram_waddr = i;
        ram_wdata = (state == S_PLACE) ? a_reg : ram_rdata;
    end

    // Insertion FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            ins_addr <= '0;
            a_reg    <= '0;
            i        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        i     <= count[A_W-1:0];
                        if (count == C_W'(DEPTH)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (count == '0) begin
                            state <= S_PLACE;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (shift) begin
                        i     <= i - A_W'(1);
                        state <= (i == A_W'(1)) ? S_PLACE : S_RD;
                    end else begin
                        // Stop above an equal entry so duplicates keep arrival order.
                        state <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    ins_addr <= i;
                    if (count != C_W'(DEPTH)) begin
                        count <= count + C_W'(1);
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // Wait for start to drop so a held request inserts only once.
                    if (!start) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    ram32x8_dp #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re_a    (ram_re),
        .raddr_a (ram_raddr),
        .rdata_a (ram_rdata),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

endmodule

// File: tb/tb_sorted_insert.sv
// Directed bench for sorted_insert: table-driven inserts plus hand sequences for
// the full-table and mid-insert reset cases.
module tb_sorted_insert;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       done;
    logic       err;
    logic       busy;
    logic [5:0] count;
    logic [4:0] ins_addr;

    int checks;
    int failures;

    sorted_insert dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .count    (count),
        .ins_addr (ins_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic [7:0] a;
        int         lat;
        int         addr;
        int         cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_chk(input int addr, input int exp);
        @(negedge clk);
        rd_addr = addr[4:0];
        @(negedge clk);
        chk($sformatf("rd_data[%0d]", addr), int'(rd_data), exp);
    endtask

    // One insertion: checks latency, busy after first edge, results, hold and release.
    task automatic do_insert(input logic [7:0] val, input int lat, input int addr,
                             input int exp_err, input int cnt);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        @(negedge clk);
        A     = val;
        start = 1'b1;
        while (n < 200 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                A = ~val;
                chk("busy_first", int'(busy), (lat > 1) ? 1 : 0);
            end
            if (done) seen = 1;
        end
        chk("done_seen", int'(seen), 1);
        chk("latency", n, lat);
        chk("ins_addr", int'(ins_addr), addr);
        chk("err", int'(err), exp_err);
        chk("count", int'(count), cnt);
        repeat (2) begin
            @(negedge clk);
            chk("hold_done", int'(done), 1);
            chk("hold_count", int'(count), cnt);
        end
        start = 1'b0;
        @(negedge clk);
        chk("release_done", int'(done), 0);
        chk("release_err", int'(err), 0);
        chk("release_busy", int'(busy), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        A        = 8'h00;
        rd_addr  = 5'd0;

        vecs[0] = '{1'b0, 8'h10, 2, 0, 1};
        vecs[1] = '{1'b0, 8'h30, 4, 1, 2};
        vecs[2] = '{1'b0, 8'h20, 6, 1, 3};
        vecs[3] = '{1'b0, 8'h05, 8, 0, 4};
        vecs[4] = '{1'b1, 8'h10, 2, 0, 1};
        vecs[5] = '{1'b0, 8'h20, 4, 1, 2};
        vecs[6] = '{1'b0, 8'h30, 4, 2, 3};
        vecs[7] = '{1'b0, 8'h20, 6, 2, 4};

        repeat (2) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ins_addr", int'(ins_addr), 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_first) begin
                do_reset();
                chk("rerst_count", int'(count), 0);
            end
            do_insert(vecs[v].a, vecs[v].lat, vecs[v].addr, 0, vecs[v].cnt);
            if (v == 0) read_chk(0, 8'h10);
            if (v == 3) begin
                read_chk(0, 8'h05);
                read_chk(1, 8'h10);
                read_chk(2, 8'h20);
                read_chk(3, 8'h30);
            end
        end
        read_chk(0, 8'h10);
        read_chk(1, 8'h20);
        read_chk(2, 8'h20);
        read_chk(3, 8'h30);

        // Fill the table, then a rejected insert must leave everything untouched.
        do_reset();
        for (int j = 0; j < 32; j++) begin
            do_insert(8'((j + 1) * 3), (j == 0) ? 2 : 4, j, 0, j + 1);
        end
        do_insert(8'h00, 1, 31, 1, 32);
        for (int j = 0; j < 32; j++) begin
            read_chk(j, (j + 1) * 3);
        end

        // Reset in S_CMP of a 3-shift insert.
        do_reset();
        do_insert(8'h10, 2, 0, 0, 1);
        do_insert(8'h20, 4, 1, 0, 2);
        do_insert(8'h30, 4, 2, 0, 3);
        @(negedge clk);
        A     = 8'h05;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_ins_addr", int'(ins_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        do_insert(8'h44, 2, 0, 0, 1);
        read_chk(0, 8'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sorted_insert.md
SORTED_INSERT -- requirements
Module: sorted_insert

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of RAM entries (address width 5).
REQ-002 SHALL have parameter WIDTH, default 8, meaning data width.
REQ-003 SHALL have ports, in this order:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  level request to insert A.
- A  input  8  value to insert.
- rd_addr  input  5  search-side read address.
- rd_data  output  8  search-side read data.
- done  output  1  insertion finished.
- err  output  1  request rejected, table full.
- busy  output  1  insertion in progress.
- count  output  6  number of valid entries, 0..32.
- ins_addr  output  5  address where A was placed.

Function
REQ-004 SHALL keep entries 0..count-1 sorted non-decreasing, unsigned, so the binary searcher can read them directly.
REQ-005 SHALL use FSM states S_IDLE, S_RD, S_CMP, S_PLACE, S_DONE.
REQ-006 In S_IDLE with start=1: SHALL register A into a_reg and count into index i.
- count==32 -> S_DONE with err=1; no RAM write.
- count==0 -> S_PLACE.
- otherwise -> S_RD.
REQ-007 In S_RD: SHALL issue an internal read of address i-1, then go to S_CMP.
REQ-008 In S_CMP, when mem[i-1] > a_reg: SHALL write mem[i]=mem[i-1] and decrement i; next state S_PLACE if the new i==0, else S_RD.
REQ-009 In S_CMP, when mem[i-1] <= a_reg: SHALL go to S_PLACE with no write; equal values are inserted after existing duplicates.
REQ-010 In S_PLACE: SHALL write mem[i]=a_reg, set ins_addr=i, increment count, then go to S_DONE.
REQ-011 In S_DONE: done=1 (err held as set); SHALL stay until start=0, then go to S_IDLE, clearing done and err on that edge.
REQ-012 Start is level-sensitive: holding start=1 SHALL produce exactly one insertion; a new insertion requires start to go 0 then 1.
REQ-013 busy SHALL be 1 in S_RD, S_CMP and S_PLACE, and 0 otherwise.
REQ-014 A, count and ins_addr SHALL be ignored or held while busy; A changes after the S_IDLE sample SHALL have no effect.
REQ-015 Latency from the edge sampling start, in edges until done=1:
- empty table: 2.
- k shifts stopping above 0: 2k+4.
- k shifts to address 0: 2k+2.
- full table: 1.
REQ-016 The read port SHALL be synchronous, 1-cycle latency, and independent of the insert port; reading an address written on the same edge SHALL return the old data; the searcher SHALL read only while busy=0.
REQ-017 count SHALL saturate at 32; ins_addr SHALL be unchanged on err.

Reset
REQ-018 Asserting reset SHALL immediately force state S_IDLE, count=0, done=0, err=0, busy=0, ins_addr=0, a_reg=0, i=0.
REQ-019 Reset SHALL NOT clear RAM contents; contents are invalid beyond count.
REQ-020 Reset mid-insertion SHALL abort with count=0; the partial shift is discarded.

Structure
REQ-021 A shared package SHALL hold DEPTH, WIDTH, the address width constant and the FSM state enum.
REQ-022 The RAM SHALL be a sub-module ram32x8_dp: one write port and two synchronous read ports, one internal and one for rd_addr.
REQ-023 The top level SHALL contain only the FSM, a_reg, i, count and output registers.

Verification
REQ-024 Reset, then start=1 with A=8'h10 -> done after 2 edges, ins_addr=0, count=1, rd_addr=0 reads 8'h10.
REQ-025 Insert 8'h10, 8'h30, 8'h20 in that order (toggling start) -> table reads 10,20,30; the third insert has ins_addr=1, done after 6 edges.
REQ-026 Insert 8'h05 into table 10,20,30 -> 2k+2 = 8 edges, ins_addr=0, table reads 05,10,20,30.
REQ-027 Insert 8'h20 into table 10,20,30 -> ins_addr=2, table reads 10,20,20,30 (placed after the duplicate).
REQ-028 Fill 32 entries, then start=1 with A=8'h00 -> done and err after 1 edge, count stays 32, RAM unchanged; start=0 clears both.
REQ-029 Assert reset during S_CMP of a 3-shift insert -> outputs at reset values immediately, count=0; a following insert of 8'h44 gives ins_addr=0.
